nes_cpu_bus_fabric: RTL and testbench
=====================================

// Module: nes_cpu_bus_fabric
// PURPOSE
//  CPU-side bus fabric of the NES architecture: decodes 2A03 address into internal RAM, PPU
//  regs, APU/IO, cartridge; muxes read data onto DATA_BUS; holds open-bus value. Hosts OAM DMA
//  engine ($4014) that halts CPU via CPU_ENABLE and copies a 256-byte page to PPU OAMDATA.
//  Sits between CPU_2A03 and all CPU-side slaves.
// PARAMETERS
//  RAM_AW      11       internal RAM addr width; RAM mirrored over $0000-$1FFF
//  PPU_RAW     3        PPU reg-select width; mirrored over $2000-$3FFF
//  DMA_LEN     256      bytes per OAM DMA (power of 2, <=256)
//  DMA_REG     16'h4014 DMA trigger address (write-only)
//  OAM_DATA    16'h2004 DMA write target address
// PORTS
//  CPU_CLK      in   1       sole clock, one tick per CPU cycle
//  RESET_n      in   1       synchronous, active-low reset
//  CPU_ADDR     in   16      CPU address
//  CPU_DATA_OUT in   8       CPU write data
//  CPU_RW_n     in   1       1=read, 0=write
//  CPU_ENABLE   out  1       0 = CPU halted (DMA owns bus)
//  DATA_BUS     out  8       read data to CPU / DMA
//  BUS_ADDR     out  16      muxed master address to slaves (CPU or DMA)
//  BUS_RW_n     out  1       muxed master RW_n
//  BUS_WDATA    out  8       muxed master write data
//  RAM_CS/PPU_CS/APU_CS/CART_CS out 1  one-hot region selects (all 0 for unmapped/DMA_REG)
//  RAM_RDATA,PPU_RDATA,APU_RDATA,CART_RDATA in 8  slave read data, valid same cycle as CS
// BEHAVIOUR
//  Reset: CPU_ENABLE=1, DMA state IDLE, count=0, parity P=0, open-bus latch=8'h00.
//  Decode on BUS_ADDR (combinational): $0000-$1FFF RAM (addr[RAM_AW-1:0]); $2000-$3FFF PPU
//   (addr[PPU_RAW-1:0]); $4000-$4017 except DMA_REG -> APU; $4020-$FFFF CART; $4018-$401F unmapped.
//  Read mux: DATA_BUS = selected slave rdata same cycle; unmapped/DMA_REG reads -> open-bus latch.
//  Open-bus latch: every cycle loads DATA_BUS on reads, BUS_WDATA on writes.
//  P toggles every cycle out of reset (free-running cycle parity).
//  DMA FSM: IDLE -> HALT -> [ALIGN] -> READ <-> WRITE -> IDLE.
//   IDLE: BUS_* = CPU_*. Cycle t with CPU write to DMA_REG: latch page=CPU_DATA_OUT -> HALT at t+1.
//   HALT: CPU_ENABLE=0 (stays 0 until back in IDLE); no bus access (BUS_RW_n=1, all CS=0).
//    next = ALIGN if P==0 in HALT, else READ (READs always on P==0).
//   ALIGN: one idle cycle, no bus access -> READ.
//   READ: BUS_ADDR={page,count}, BUS_RW_n=1; latch DATA_BUS into dma_byte -> WRITE.
//   WRITE: BUS_ADDR=OAM_DATA, BUS_RW_n=0, BUS_WDATA=dma_byte; count++ ;
//    count==DMA_LEN-1 -> IDLE (count wraps to 0) else READ.
//   Total halt = 1 + align(0/1) + 2*DMA_LEN cycles (513/514 for 256); CPU_ENABLE=1 on first IDLE cycle.
//  Page wrap: address is {page,count[7:0]}; never carries into page.
//  DMA from page $20-$3F reads PPU regs (side effects allowed); page $40 reads through APU/open bus.
//  DMA_REG write while DMA active impossible (CPU halted); CPU_* ignored outside IDLE.
//  RESET_n low mid-DMA: next edge IDLE, CPU_ENABLE=1, count=0; no further OAM writes.
//  No pipelining: zero-cycle read latency; slaves present rdata combinationally from CS/addr.
// TESTING
//  RAM mirror: write $55 to $0001, read $0801/$1801 -> RAM_CS=1, addr 11'h001, DATA_BUS=$55.
//  PPU mirror: read $3FFA -> PPU_CS=1, reg 3'h2; write $2007 -> PPU_CS, BUS_RW_n=0, wdata passed.
//  Open bus: write $A5 to $4018 then read $4019 -> all CS=0, DATA_BUS=$A5.
//  DMA even: write $02 to $4014 with HALT at P=1 -> CPU_ENABLE low 513 cycles; 256 writes
//   to $2004 with bytes from $0200..$02FF in order; CPU_ENABLE=1 on cycle 514.
//  DMA odd: same with HALT at P=0 -> one ALIGN cycle, 514 halted cycles, data identical.
//  Reset mid-DMA: assert RESET_n=0 after 40 OAM writes -> next edge CPU_ENABLE=1, IDLE, no more $2004 writes.

Source files
------------

// File: rtl/nes_cpu_bus_fabric.sv
// CPU-side NES bus fabric: region decode, read-data mux with open-bus latch,
// and the $4014 OAM DMA engine that halts the 2A03 while copying a page to OAMDATA.
module nes_cpu_bus_fabric #(
  parameter int unsigned RAM_AW   = 11,
  parameter int unsigned PPU_RAW  = 3,
  parameter int unsigned DMA_LEN  = 256,
  parameter logic [15:0] DMA_REG  = 16'h4014,
  parameter logic [15:0] OAM_DATA = 16'h2004
) (
  input  logic        CPU_CLK,
  input  logic        RESET_n,
  input  logic [15:0] CPU_ADDR,
  input  logic [7:0]  CPU_DATA_OUT,
  input  logic        CPU_RW_n,
  output logic        CPU_ENABLE,
  output logic [7:0]  DATA_BUS,
  output logic [15:0] BUS_ADDR,
  output logic        BUS_RW_n,
  output logic [7:0]  BUS_WDATA,
  output logic        RAM_CS,
  output logic        PPU_CS,
  output logic        APU_CS,
  output logic        CART_CS,
  input  logic [7:0]  RAM_RDATA,
  input  logic [7:0]  PPU_RDATA,
  input  logic [7:0]  APU_RDATA,
  input  logic [7:0]  CART_RDATA
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } dma_state_t;

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_t r_state, w_next;
  logic [7:0] r_page;
  logic [7:0] r_count;
  logic [7:0] r_dma_byte;
  logic [7:0] r_open_bus;
  logic       r_parity;

  logic       w_dma_trig;
  logic       w_access;
  logic       w_unused_slave_offsets;

  assign w_dma_trig = (r_state == S_IDLE) && !CPU_RW_n && (CPU_ADDR == DMA_REG);
  assign CPU_ENABLE = (r_state == S_IDLE);

  // Slaves slice their own mirrored offsets straight from BUS_ADDR.
  assign w_unused_slave_offsets = ^{BUS_ADDR[RAM_AW-1:0], BUS_ADDR[PPU_RAW-1:0]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_dma_trig) w_next = S_HALT;
      S_HALT:  w_next = r_parity ? S_READ : S_ALIGN;
      S_ALIGN: w_next = S_READ;
      S_READ:  w_next = S_WRITE;
      S_WRITE: w_next = (r_count == LAST_IDX) ? S_IDLE : S_READ;
      default: w_next = S_IDLE;
    endcase
  end

  // DMA bus cycles are suppressed while reset is asserted so no OAM write
  // can slip out on the cycle that aborts a transfer.
  always_comb begin
    BUS_ADDR  = CPU_ADDR;
    BUS_RW_n  = CPU_RW_n;
    BUS_WDATA = CPU_DATA_OUT;
    w_access  = 1'b1;
    case (r_state)
      S_IDLE: ;
      S_READ: begin
        BUS_ADDR  = {r_page, r_count};
        BUS_RW_n  = 1'b1;
        BUS_WDATA = r_dma_byte;
        w_access  = RESET_n;
      end
      S_WRITE: begin
        BUS_ADDR  = OAM_DATA;
        BUS_RW_n  = !RESET_n;
        BUS_WDATA = r_dma_byte;
        w_access  = RESET_n;
      end
      default: begin
        BUS_ADDR  = {r_page, r_count};
        BUS_RW_n  = 1'b1;
        BUS_WDATA = r_dma_byte;
        w_access  = 1'b0;
      end
    endcase
  end

  assign RAM_CS  = w_access && (BUS_ADDR[15:13] == 3'b000);
  assign PPU_CS  = w_access && (BUS_ADDR[15:13] == 3'b001);
  assign APU_CS  = w_access && (BUS_ADDR[15:5] == 11'h200) && (BUS_ADDR[4:0] <= 5'h17)
                   && (BUS_ADDR != DMA_REG);
  assign CART_CS = w_access && (BUS_ADDR >= 16'h4020);

  always_comb begin
    DATA_BUS = r_open_bus;
    if (RAM_CS)       DATA_BUS = RAM_RDATA;
    else if (PPU_CS)  DATA_BUS = PPU_RDATA;
    else if (APU_CS)  DATA_BUS = APU_RDATA;
    else if (CART_CS) DATA_BUS = CART_RDATA;
  end

  always_ff @(posedge CPU_CLK) begin
    if (!RESET_n) begin
      r_state    <= S_IDLE;
      r_page     <= '0;
      r_count    <= '0;
      r_dma_byte <= '0;
      r_open_bus <= '0;
      r_parity   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_parity   <= ~r_parity;
      r_open_bus <= BUS_RW_n ? DATA_BUS : BUS_WDATA;
      if (w_dma_trig)          r_page     <= CPU_DATA_OUT;
      if (r_state == S_READ)   r_dma_byte <= DATA_BUS;
      if (r_state == S_WRITE)  r_count    <= (r_count == LAST_IDX) ? '0 : r_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_nes_cpu_bus_fabric.sv
// Directed bench for nes_cpu_bus_fabric: decode/mux vectors, even/odd OAM DMA, reset mid-DMA.
module tb_nes_cpu_bus_fabric;

  logic        CPU_CLK = 1'b0;
  logic        RESET_n = 1'b0;
  logic [15:0] CPU_ADDR = 16'h4018;
  logic [7:0]  CPU_DATA_OUT = 8'h00;
  logic        CPU_RW_n = 1'b1;
  logic        CPU_ENABLE;
  logic [7:0]  DATA_BUS;
  logic [15:0] BUS_ADDR;
  logic        BUS_RW_n;
  logic [7:0]  BUS_WDATA;
  logic        RAM_CS, PPU_CS, APU_CS, CART_CS;
  logic [7:0]  RAM_RDATA, PPU_RDATA, APU_RDATA, CART_RDATA;

  nes_cpu_bus_fabric #(
    .RAM_AW(11), .PPU_RAW(3), .DMA_LEN(256), .DMA_REG(16'h4014), .OAM_DATA(16'h2004)
  ) dut (
    .CPU_CLK(CPU_CLK), .RESET_n(RESET_n), .CPU_ADDR(CPU_ADDR), .CPU_DATA_OUT(CPU_DATA_OUT),
    .CPU_RW_n(CPU_RW_n), .CPU_ENABLE(CPU_ENABLE), .DATA_BUS(DATA_BUS), .BUS_ADDR(BUS_ADDR),
    .BUS_RW_n(BUS_RW_n), .BUS_WDATA(BUS_WDATA), .RAM_CS(RAM_CS), .PPU_CS(PPU_CS),
    .APU_CS(APU_CS), .CART_CS(CART_CS), .RAM_RDATA(RAM_RDATA), .PPU_RDATA(PPU_RDATA),
    .APU_RDATA(APU_RDATA), .CART_RDATA(CART_RDATA)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  function automatic logic [7:0] ram_init(input logic [10:0] a);
    logic [7:0] lo3;
    lo3 = a[7:0] * 8'd3;
    return lo3 ^ {a[10:8], 5'b00000};
  endfunction

  // Slave models
  logic [7:0] ram [0:2047];
  assign RAM_RDATA  = ram[BUS_ADDR[10:0]];
  assign PPU_RDATA  = 8'hA0 | {5'b00000, BUS_ADDR[2:0]};
  assign APU_RDATA  = 8'h40 ^ BUS_ADDR[7:0];
  assign CART_RDATA = BUS_ADDR[15:8] ^ BUS_ADDR[7:0];

  always @(posedge CPU_CLK) begin
    if (!RESET_n) begin
      for (int i = 0; i < 2048; i++) ram[i] <= ram_init(11'(i));
    end else if (RAM_CS && !BUS_RW_n) begin
      ram[BUS_ADDR[10:0]] <= BUS_WDATA;
    end
  end

  logic [7:0]  oam_log [0:1023];
  int unsigned oam_cnt = 0;
  always @(posedge CPU_CLK) begin
    if (PPU_CS && !BUS_RW_n && BUS_ADDR == 16'h2004) begin
      if (oam_cnt < 1024) oam_log[oam_cnt] <= BUS_WDATA;
      oam_cnt <= oam_cnt + 1;
    end
  end

  logic tb_p = 1'b0;
  always @(posedge CPU_CLK) tb_p <= RESET_n ? ~tb_p : 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        rw_n;
    logic [7:0]  wdata;
    logic [3:0]  cs;      // {RAM,PPU,APU,CART}
    logic [7:0]  rdata;
  } vec_t;

  vec_t vecs [16];

  task automatic run_dma(input logic [7:0] page, input logic want_align, input string tag);
    int unsigned base, halted, guard;
    base  = oam_cnt;
    guard = 0;
    @(posedge CPU_CLK); #1;
    while (tb_p != want_align && guard < 4) begin
      @(posedge CPU_CLK); #1;
      guard++;
    end
    CPU_ADDR = 16'h4014; CPU_RW_n = 1'b0; CPU_DATA_OUT = page;
    @(negedge CPU_CLK);
    chk({tag, "_trig_en"}, 32'(CPU_ENABLE), 32'd1);
    chk({tag, "_trig_cs"}, 32'({RAM_CS, PPU_CS, APU_CS, CART_CS}), 32'd0);
    @(posedge CPU_CLK); #1;
    // CPU keeps driving a RAM write while halted; it must be ignored.
    CPU_ADDR = 16'h0005; CPU_RW_n = 1'b0; CPU_DATA_OUT = 8'hEE;
    halted = 0;
    do begin
      @(negedge CPU_CLK);
      if (!CPU_ENABLE) halted++;
    end while (!CPU_ENABLE && halted < 1000);
    CPU_ADDR = 16'h0000; CPU_RW_n = 1'b1;
    chk({tag, "_halt_cycles"}, halted, 32'(513 + int'(want_align)));
    chk({tag, "_oam_count"}, oam_cnt - base, 32'd256);
    for (int k = 0; k < 256; k++)
      chk($sformatf("%s_oam_byte%0d", tag, k), 32'(oam_log[base + k]),
          32'(ram_init({page[2:0], 8'(k)})));
    chk({tag, "_cpu_write_ignored"}, 32'(ram[5]), 32'(ram_init(11'h005)));
  endtask

  initial begin
    int unsigned base, guard, low;

    vecs[0]  = '{16'h0001, 1'b0, 8'h55, 4'b1000, 8'h00};
    vecs[1]  = '{16'h0801, 1'b1, 8'h00, 4'b1000, 8'h55};
    vecs[2]  = '{16'h1801, 1'b1, 8'h00, 4'b1000, 8'h55};
    vecs[3]  = '{16'h3FFA, 1'b1, 8'h00, 4'b0100, 8'hA2};
    vecs[4]  = '{16'h2007, 1'b0, 8'h3C, 4'b0100, 8'h00};
    vecs[5]  = '{16'h4018, 1'b0, 8'hA5, 4'b0000, 8'h00};
    vecs[6]  = '{16'h4019, 1'b1, 8'h00, 4'b0000, 8'hA5};
    vecs[7]  = '{16'h4000, 1'b1, 8'h00, 4'b0010, 8'h40};
    vecs[8]  = '{16'h4017, 1'b1, 8'h00, 4'b0010, 8'h57};
    vecs[9]  = '{16'h4014, 1'b1, 8'h00, 4'b0000, 8'h57};
    vecs[10] = '{16'h4020, 1'b1, 8'h00, 4'b0001, 8'h60};
    vecs[11] = '{16'hFFFC, 1'b1, 8'h00, 4'b0001, 8'h03};
    vecs[12] = '{16'h401F, 1'b1, 8'h00, 4'b0000, 8'h03};
    vecs[13] = '{16'h1FFF, 1'b1, 8'h00, 4'b1000, 8'h1D};
    vecs[14] = '{16'h0200, 1'b1, 8'h00, 4'b1000, 8'h40};
    vecs[15] = '{16'h3FFF, 1'b1, 8'h00, 4'b0100, 8'hA7};

    repeat (3) @(posedge CPU_CLK);
    @(negedge CPU_CLK);
    chk("reset_cpu_enable", 32'(CPU_ENABLE), 32'd1);
    chk("reset_open_bus", 32'(DATA_BUS), 32'h00);
    chk("reset_cs", 32'({RAM_CS, PPU_CS, APU_CS, CART_CS}), 32'd0);
    @(posedge CPU_CLK); #1;
    RESET_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(posedge CPU_CLK); #1;
      CPU_ADDR = vecs[i].addr; CPU_RW_n = vecs[i].rw_n; CPU_DATA_OUT = vecs[i].wdata;
      @(negedge CPU_CLK);
      chk($sformatf("v%0d_cs", i), 32'({RAM_CS, PPU_CS, APU_CS, CART_CS}), 32'(vecs[i].cs));
      chk($sformatf("v%0d_addr", i), 32'(BUS_ADDR), 32'(vecs[i].addr));
      chk($sformatf("v%0d_rw", i), 32'(BUS_RW_n), 32'(vecs[i].rw_n));
      chk($sformatf("v%0d_en", i), 32'(CPU_ENABLE), 32'd1);
      if (vecs[i].rw_n) chk($sformatf("v%0d_rdata", i), 32'(DATA_BUS), 32'(vecs[i].rdata));
      else              chk($sformatf("v%0d_wdata", i), 32'(BUS_WDATA), 32'(vecs[i].wdata));
    end
    @(posedge CPU_CLK); #1;
    CPU_ADDR = 16'h0000; CPU_RW_n = 1'b1;

    run_dma(8'h02, 1'b0, "dma_even");
    run_dma(8'h02, 1'b1, "dma_odd");

    // Reset asserted after the 40th OAM write of a third transfer.
    base = oam_cnt;
    @(posedge CPU_CLK); #1;
    CPU_ADDR = 16'h4014; CPU_RW_n = 1'b0; CPU_DATA_OUT = 8'h02;
    @(posedge CPU_CLK); #1;
    CPU_ADDR = 16'h0000; CPU_RW_n = 1'b1;
    guard = 0;
    while (oam_cnt - base < 40 && guard < 2000) begin
      @(posedge CPU_CLK); #1;
      guard++;
    end
    chk("rst_mid_reached40", oam_cnt - base, 32'd40);
    RESET_n = 1'b0;
    @(posedge CPU_CLK); #1;
    chk("rst_mid_cpu_enable", 32'(CPU_ENABLE), 32'd1);
    RESET_n = 1'b1;
    low = 0;
    repeat (600) begin
      @(negedge CPU_CLK);
      if (!CPU_ENABLE) low++;
    end
    chk("rst_mid_halt_after", low, 32'd0);
    chk("rst_mid_oam_count", oam_cnt - base, 32'd40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
